// File: rtl/fusion_issue_ctrl.sv
// fusion_issue_ctrl: initiator side of the fusion-unit operand interface.
// Packs per-element in/weight pairs LSB-first into 8-bit fusion words,
// presents one word pair per issue to a combinational fusion unit, and
// accumulates the returned 16-bit psum over cfg_len issues.
// Optional build macro FUSION_ACC_SAT_EN: saturating accumulator plus a
// sticky res_sat output. Without it the accumulator wraps modulo 2^ACC_W.
module fusion_issue_ctrl #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_in_width,
  input  logic [3:0]       cfg_weight_width,
  input  logic             cfg_s_in,
  input  logic             cfg_s_weight,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             cfg_err,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_in,
  input  logic [7:0]       op_weight,
  output logic [7:0]       fu_in,
  output logic [7:0]       fu_weight,
  output logic [3:0]       fu_in_width,
  output logic [3:0]       fu_weight_width,
  output logic             fu_s_in,
  output logic             fu_s_weight,
  input  logic [15:0]      fu_psum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data
`ifdef FUSION_ACC_SAT_EN
  ,
  output logic             res_sat
`endif
);

`ifdef FUSION_ACC_SAT_EN
  localparam int NXT_W = ACC_W + 1;  // extra MSB carries the clamp flag
`else
  localparam int NXT_W = ACC_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_ISSUE, S_DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_in_w;
  logic [3:0]       r_wt_w;
  logic             r_s_in;
  logic             r_s_wt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_issue_cnt;
  logic [1:0]       r_lane;
  logic [1:0]       r_lane_last;
  logic [7:0]       r_fu_in;
  logic [7:0]       r_fu_wt;
  logic [ACC_W-1:0] r_acc;
  logic             r_cfg_err;
`ifdef FUSION_ACC_SAT_EN
  logic             r_sat;
`endif

  logic [NXT_W-1:0] w_acc_nxt;
  logic             w_cfg_legal;

  function automatic logic width_legal(input logic [3:0] w);
    return (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
  endfunction

  // Last lane index of a word: P-1 where P = 8 / max(in_w, wt_w).
  function automatic logic [1:0] lane_last(input logic [3:0] iw, input logic [3:0] ww);
    logic [3:0] mx;
    mx = (iw > ww) ? iw : ww;
    case (mx)
      4'd8:    return 2'd0;
      4'd4:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Truncate an element to its width and move it to its lane position.
  function automatic logic [7:0] place(input logic [7:0] elem, input logic [3:0] w,
                                       input logic [1:0] lane);
    logic [7:0]  mask;
    logic [15:0] t;
    logic [5:0]  sh;
    case (w)
      4'd2:    mask = 8'h03;
      4'd4:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    t  = {8'h00, elem & mask};
    sh = 6'(lane) * 6'(w);
    t  = t << sh;
    return t[7:0];
  endfunction

  // Accumulate one psum; sign- or zero-extended depending on operand signs.
  function automatic logic [NXT_W-1:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [15:0] psum, input logic sgn);
    logic [ACC_W-1:0] ext;
`ifdef FUSION_ACC_SAT_EN
    logic signed [ACC_W:0] s_sum;
    logic [ACC_W:0]        u_sum;
`endif
    ext = sgn ? {{(ACC_W-16){psum[15]}}, psum} : {{(ACC_W-16){1'b0}}, psum};
`ifdef FUSION_ACC_SAT_EN
    if (sgn) begin
      s_sum = $signed({acc[ACC_W-1], acc}) + $signed({ext[ACC_W-1], ext});
      if (s_sum[ACC_W] != s_sum[ACC_W-1]) begin
        // Overflow direction follows the true sign in the extra bit.
        if (s_sum[ACC_W]) return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
        else              return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
      return {1'b0, s_sum[ACC_W-1:0]};
    end else begin
      u_sum = {1'b0, acc} + {1'b0, ext};
      if (u_sum[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
      return {1'b0, u_sum[ACC_W-1:0]};
    end
`else
    return acc + ext;
`endif
  endfunction

  assign w_acc_nxt   = acc_add(r_acc, fu_psum, r_s_in | r_s_wt);
  assign w_cfg_legal = width_legal(cfg_in_width) && width_legal(cfg_weight_width);

  assign cfg_ready       = (r_state == S_IDLE);
  assign op_ready        = (r_state == S_PACK);
  assign res_valid       = (r_state == S_DONE);
  assign res_data        = r_acc;
  assign cfg_err         = r_cfg_err;
  assign fu_in           = r_fu_in;
  assign fu_weight       = r_fu_wt;
  assign fu_in_width     = r_in_w;
  assign fu_weight_width = r_wt_w;
  assign fu_s_in         = r_s_in;
  assign fu_s_weight     = r_s_wt;
`ifdef FUSION_ACC_SAT_EN
  assign res_sat         = r_sat;
`endif

  // Job FSM: config accept, element packing, issue/accumulate, result hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_w      <= '0;
      r_wt_w      <= '0;
      r_s_in      <= 1'b0;
      r_s_wt      <= 1'b0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_lane      <= '0;
      r_lane_last <= '0;
      r_fu_in     <= '0;
      r_fu_wt     <= '0;
      r_acc       <= '0;
      r_cfg_err   <= 1'b0;
`ifdef FUSION_ACC_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_valid) begin
            if (!w_cfg_legal) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_in_w      <= cfg_in_width;
              r_wt_w      <= cfg_weight_width;
              r_s_in      <= cfg_s_in;
              r_s_wt      <= cfg_s_weight;
              r_len       <= cfg_len;
              r_lane_last <= lane_last(cfg_in_width, cfg_weight_width);
              r_issue_cnt <= '0;
              r_lane      <= '0;
              r_fu_in     <= '0;
              r_fu_wt     <= '0;
              r_acc       <= '0;
`ifdef FUSION_ACC_SAT_EN
              r_sat       <= 1'b0;
`endif
              r_state     <= (cfg_len == '0) ? S_DONE : S_PACK;
            end
          end
        end
        S_PACK: begin
          if (op_valid) begin
            r_fu_in <= r_fu_in | place(op_in, r_in_w, r_lane);
            r_fu_wt <= r_fu_wt | place(op_weight, r_wt_w, r_lane);
            r_lane  <= r_lane + 2'd1;
            if (r_lane == r_lane_last) r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef FUSION_ACC_SAT_EN
          r_acc <= w_acc_nxt[ACC_W-1:0];
          r_sat <= r_sat | w_acc_nxt[ACC_W];
`else
          r_acc <= w_acc_nxt;
`endif
          r_issue_cnt <= r_issue_cnt + LEN_W'(1);
          if (r_issue_cnt == r_len - LEN_W'(1)) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_PACK;
            r_fu_in <= '0;
            r_fu_wt <= '0;
            r_lane  <= '0;
          end
        end
        S_DONE: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fusion_issue_ctrl.sv
// Directed bench for fusion_issue_ctrl with a behavioural fusion-unit model
// and a result scoreboard.
module tb_fusion_issue_ctrl;
  localparam int ACC_W = 17;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_valid, cfg_ready;
  logic [3:0]       cfg_in_width, cfg_weight_width;
  logic             cfg_s_in, cfg_s_weight;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_err;
  logic             op_valid, op_ready;
  logic [7:0]       op_in, op_weight;
  logic [7:0]       fu_in, fu_weight;
  logic [3:0]       fu_in_width, fu_weight_width;
  logic             fu_s_in, fu_s_weight;
  logic [15:0]      fu_psum;
  logic             res_valid, res_ready;
  logic [ACC_W-1:0] res_data;
`ifdef FUSION_ACC_SAT_EN
  logic             res_sat;
`endif

  logic        psum_force_en;
  logic [15:0] psum_force;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  fusion_issue_ctrl #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
    .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight),
    .cfg_len(cfg_len), .cfg_err(cfg_err),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_in(op_in), .op_weight(op_weight),
    .fu_in(fu_in), .fu_weight(fu_weight),
    .fu_in_width(fu_in_width), .fu_weight_width(fu_weight_width),
    .fu_s_in(fu_s_in), .fu_s_weight(fu_s_weight),
    .fu_psum(fu_psum),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
`ifdef FUSION_ACC_SAT_EN
    , .res_sat(res_sat)
`endif
  );

  always #5 clk = ~clk;

  // Fusion unit: sum of lane-wise products with per-operand sign handling.
  function automatic logic [15:0] fu_model(input logic [7:0] fi, input logic [7:0] fw,
                                           input logic [3:0] iw, input logic [3:0] ww,
                                           input logic si, input logic sw);
    int mx, p, a, b, sum;
    sum = 0;
    mx = (iw > ww) ? int'(iw) : int'(ww);
    if (mx == 0) return 16'h0000;
    p = 8 / mx;
    for (int k = 0; k < p; k++) begin
      a = (int'(fi) >> (k * int'(iw))) & ((1 << iw) - 1);
      b = (int'(fw) >> (k * int'(ww))) & ((1 << ww) - 1);
      if (si && a >= (1 << (iw - 1))) a = a - (1 << iw);
      if (sw && b >= (1 << (ww - 1))) b = b - (1 << ww);
      sum = sum + a * b;
    end
    return 16'(sum);
  endfunction

  always_comb begin
    fu_psum = fu_model(fu_in, fu_weight, fu_in_width, fu_weight_width, fu_s_in, fu_s_weight);
    if (psum_force_en) fu_psum = psum_force;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cfg(input logic [3:0] iw, input logic [3:0] ww, input logic si,
                          input logic sw, input logic [LEN_W-1:0] len);
    cfg_valid = 1'b1; cfg_in_width = iw; cfg_weight_width = ww;
    cfg_s_in = si; cfg_s_weight = sw; cfg_len = len;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] i, input logic [7:0] w);
    int t = 0;
    while (!op_ready && t < 20) begin tick(); t++; end
    chk("op_ready", 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_in = i; op_weight = w;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic get_result(input string tag);
    int t = 0;
    logic [31:0] e;
    while (!res_valid && t < 30) begin tick(); t++; end
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    if (res_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(tag, 32'(res_data), e);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk({tag, "_idle"}, 32'(cfg_ready), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_in_width = 4'd0; cfg_weight_width = 4'd0;
    cfg_s_in = 1'b0; cfg_s_weight = 1'b0; cfg_len = '0;
    op_valid = 1'b0; op_in = 8'h00; op_weight = 8'h00; res_ready = 1'b0;
    psum_force_en = 1'b0; psum_force = 16'h0000;
    tick(); tick();
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_fu_in", 32'(fu_in), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    reset = 1'b0;
    tick();

    // 8/8 unsigned, single word (3,5)
    sb_q.push_back(32'd15);
    send_cfg(4'd8, 4'd8, 1'b0, 1'b0, 16'd1);
    send_op(8'h03, 8'h05);
    chk("t1_fu_in", 32'(fu_in), 32'h03);
    chk("t1_fu_wt", 32'(fu_weight), 32'h05);
    chk("t1_issue_op_ready", 32'(op_ready), 32'd0);
    tick();
    chk("t1_latency", 32'(res_valid), 32'd1);
    get_result("t1_res");

    // 2/2 unsigned, two words, upper element bits truncated
    sb_q.push_back(32'd24);
    send_cfg(4'd2, 4'd2, 1'b0, 1'b0, 16'd2);
    send_op(8'h01, 8'h01);
    chk("t2_partial", 32'(fu_in), 32'h01);
    send_op(8'h02, 8'h01);
    send_op(8'h03, 8'h01);
    send_op(8'h00, 8'h01);
    chk("t2_w0_in", 32'(fu_in), 32'h39);
    chk("t2_w0_wt", 32'(fu_weight), 32'h55);
    tick();
    chk("t2_cleared", 32'(fu_in), 32'h00);
    send_op(8'hFF, 8'h02);
    send_op(8'h03, 8'h01);
    send_op(8'h03, 8'h02);
    send_op(8'h03, 8'h01);
    chk("t2_w1_in", 32'(fu_in), 32'hFF);
    chk("t2_w1_wt", 32'(fu_weight), 32'h66);
    get_result("t2_res");

    // 4/2 unsigned: P=2, unfilled weight bits stay zero
    sb_q.push_back(32'd35);
    send_cfg(4'd4, 4'd2, 1'b0, 1'b0, 16'd1);
    send_op(8'hF5, 8'hFB);
    send_op(8'h0A, 8'h02);
    chk("t2b_in", 32'(fu_in), 32'hA5);
    chk("t2b_wt", 32'(fu_weight), 32'h0B);
    get_result("t2b_res");

    // 4/8 signed (-1,-2) then forced psum FFFF
    sb_q.push_back(32'd1);
    send_cfg(4'd4, 4'd8, 1'b1, 1'b1, 16'd2);
    send_op(8'hFF, 8'hFE);
    chk("t3_in", 32'(fu_in), 32'h0F);
    chk("t3_wt", 32'(fu_weight), 32'hFE);
    tick();
    psum_force_en = 1'b1; psum_force = 16'hFFFF;
    send_op(8'h01, 8'h01);
    get_result("t3_res");
    sb_q.push_back(32'h1FFFF);
    send_cfg(4'd8, 4'd8, 1'b1, 1'b0, 16'd1);
    send_op(8'h01, 8'h01);
    get_result("t3_sext");
    sb_q.push_back(32'h0FFFF);
    send_cfg(4'd8, 4'd8, 1'b0, 1'b0, 16'd1);
    send_op(8'h01, 8'h01);
    get_result("t3_zext");
    psum_force_en = 1'b0;

    // illegal width, then zero-length job
    cfg_valid = 1'b1; cfg_in_width = 4'd3; cfg_weight_width = 4'd8; cfg_len = 16'd1;
    tick();
    cfg_valid = 1'b0;
    chk("t4_err", 32'(cfg_err), 32'd1);
    chk("t4_ready", 32'(cfg_ready), 32'd1);
    chk("t4_no_pack", 32'(op_ready), 32'd0);
    chk("t4_width_kept", 32'(fu_in_width), 32'd8);
    tick();
    chk("t4_err_pulse", 32'(cfg_err), 32'd0);
    sb_q.push_back(32'd0);
    send_cfg(4'd8, 4'd8, 1'b0, 1'b0, 16'd0);
    chk("t4_len0_valid", 32'(res_valid), 32'd1);
    get_result("t4_len0");

    // back-pressure on the result, then reset mid-PACK
    sb_q.push_back(32'd63);
    send_cfg(4'd8, 4'd8, 1'b0, 1'b0, 16'd1);
    send_op(8'h07, 8'h09);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", 32'(res_valid), 32'd1);
      chk("t5_hold_data", 32'(res_data), 32'd63);
      tick();
    end
    get_result("t5_res");
    send_cfg(4'd2, 4'd2, 1'b0, 1'b0, 16'd1);
    send_op(8'h03, 8'h03);
    chk("t5_pre_rst", 32'(fu_in), 32'h03);
    reset = 1'b1;
    tick();
    chk("t5_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("t5_rst_op_ready", 32'(op_ready), 32'd0);
    chk("t5_rst_fu_in", 32'(fu_in), 32'd0);
    chk("t5_rst_fu_wt", 32'(fu_weight), 32'd0);
    chk("t5_rst_width", 32'(fu_in_width), 32'd0);
    chk("t5_rst_res_valid", 32'(res_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("t5_no_result", 32'(res_valid), 32'd0);

    // accumulator boundary at ACC_W=17, signed, three psums of 7FFF
    psum_force_en = 1'b1; psum_force = 16'h7FFF;
`ifdef FUSION_ACC_SAT_EN
    sb_q.push_back(32'h0FFFF);
`else
    sb_q.push_back(32'h17FFD);
`endif
    send_cfg(4'd8, 4'd8, 1'b1, 1'b1, 16'd3);
    send_op(8'h01, 8'h01);
    send_op(8'h01, 8'h01);
`ifdef FUSION_ACC_SAT_EN
    tick();
    chk("t6_sat_clear", 32'(res_sat), 32'd0);
`endif
    send_op(8'h01, 8'h01);
`ifdef FUSION_ACC_SAT_EN
    tick();
    chk("t6_sat_set", 32'(res_sat), 32'd1);
`endif
    get_result("t6_res");
    psum_force_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
